// File: rtl/writeback_pkg.sv
// Shared constants and types for the write-back select pipeline.
// Source indices name the datapath words feeding the register-file write port.
package writeback_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DROP_CNT_W = 8;

   localparam int SRC_LS       = 0;
   localparam int SRC_HI       = 1;
   localparam int SRC_LO       = 2;
   localparam int SRC_SHIFT    = 3;
   localparam int SRC_CONST227 = 4;
   localparam int SRC_SE1_32   = 5;
   localparam int SRC_ALUOUT   = 6;

   typedef enum logic [1:0] {
      Q_EMPTY   = 2'd0,
      Q_PARTIAL = 2'd1,
      Q_FULL    = 2'd2
   } q_state_e;

   // Saturating increment used by the register-0 drop counter.
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      logic [DROP_CNT_W-1:0] r;
      if (v == {DROP_CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + DROP_CNT_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_src_mux.sv
// Combinational write-back source selector; an out-of-range select yields zero
// data and raises sel_err.
module wb_src_mux #(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 8,
   parameter int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [SEL_W-1:0]          sel,
   output logic [DATA_W-1:0]         data,
   output logic                      sel_err
);

   // Scan all sources; the zero/error defaults cover any unmatched select.
   always_comb begin
      data    = {DATA_W{1'b0}};
      sel_err = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (int'(sel) == k) begin
            data    = src_data[k*DATA_W +: DATA_W];
            sel_err = 1'b0;
         end else begin
            data    = data;
            sel_err = sel_err;
         end
      end
   end

endmodule

// File: rtl/writeback_select_pipe.sv
// Write-back source select followed by a small output queue toward the
// register file, with register-0 drop counting and a sticky bad-select flag.
module writeback_select_pipe
   import writeback_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 8,
   parameter int DEPTH   = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC*DATA_W-1:0]     src_data,
   input  logic [$clog2(NUM_SRC)-1:0]    src_sel,
   input  logic [REG_ADDR_W-1:0]         dst_addr,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic [REG_ADDR_W-1:0]         out_addr,
   output logic                          out_valid,
   input  logic                          out_ready,
   input  logic                          flush,
   input  logic                          err_clr,
   output logic                          err_sel,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic [DROP_CNT_W-1:0]         drop_cnt
);

   localparam int SEL_W = $clog2(NUM_SRC);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0]     mux_data_s;
   logic                  sel_err_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  enq_s;
   logic                  drop_s;
   logic [CNT_W-1:0]      count_nxt_s;

   q_state_e              state_r;
   logic [CNT_W-1:0]      count_r;
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [DATA_W-1:0]     mem_data_r [DEPTH];
   logic [REG_ADDR_W-1:0] mem_addr_r [DEPTH];
   logic                  err_sel_r;
   logic [DROP_CNT_W-1:0] drop_cnt_r;

   // Wrap modulo DEPTH so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == LAST_PTR) begin
         r = {PTR_W{1'b0}};
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   wb_src_mux #(
      .DATA_W  (DATA_W),
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_mux (
      .src_data (src_data),
      .sel      (src_sel),
      .data     (mux_data_s),
      .sel_err  (sel_err_s)
   );

   assign in_ready  = (state_r != Q_FULL);
   assign out_valid = (state_r != Q_EMPTY);
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;
   assign enq_s     = push_s && (dst_addr != {REG_ADDR_W{1'b0}});
   assign drop_s    = push_s && (dst_addr == {REG_ADDR_W{1'b0}});

   // Occupancy after this cycle's enqueue/pop, ignoring flush.
   always_comb begin
      count_nxt_s = count_r;
      if (enq_s && !pop_s) begin
         count_nxt_s = count_r + CNT_W'(1);
      end else if (pop_s && !enq_s) begin
         count_nxt_s = count_r - CNT_W'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Queue state machine with its count and pointers; flush outranks push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= Q_EMPTY;
         count_r  <= {CNT_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else if (flush) begin
         state_r  <= Q_EMPTY;
         count_r  <= {CNT_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         count_r <= count_nxt_s;
         if (enq_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case (state_r)
            Q_EMPTY: begin
               if (enq_s) begin
                  state_r <= (DEPTH == 1) ? Q_FULL : Q_PARTIAL;
               end else begin
                  state_r <= Q_EMPTY;
               end
            end
            Q_PARTIAL: begin
               if (enq_s && !pop_s && (count_r == DEPTH_M1_C)) begin
                  state_r <= Q_FULL;
               end else if (pop_s && !enq_s && (count_r == CNT_W'(1))) begin
                  state_r <= Q_EMPTY;
               end else begin
                  state_r <= Q_PARTIAL;
               end
            end
            Q_FULL: begin
               // No enqueue is possible here since in_ready is low.
               if (pop_s) begin
                  state_r <= (DEPTH_C == CNT_W'(1)) ? Q_EMPTY : Q_PARTIAL;
               end else begin
                  state_r <= Q_FULL;
               end
            end
            default: begin
               state_r <= Q_EMPTY;
            end
         endcase
      end
   end

   // Entry storage; only the tail slot is written so the head stays stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data_r[i] <= {DATA_W{1'b0}};
            mem_addr_r[i] <= {REG_ADDR_W{1'b0}};
         end
      end else if (enq_s && !flush) begin
         mem_data_r[wr_ptr_r] <= mux_data_s;
         mem_addr_r[wr_ptr_r] <= dst_addr;
      end else begin
         mem_data_r <= mem_data_r;
         mem_addr_r <= mem_addr_r;
      end
   end

   // Sticky bad-select flag; a new error outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_sel_r <= 1'b0;
      end else if (push_s && sel_err_s) begin
         err_sel_r <= 1'b1;
      end else if (err_clr) begin
         err_sel_r <= 1'b0;
      end else begin
         err_sel_r <= err_sel_r;
      end
   end

   // Count writes aimed at register 0; a flushed push is not counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_r <= {DROP_CNT_W{1'b0}};
      end else if (drop_s && !flush) begin
         drop_cnt_r <= sat_inc(drop_cnt_r);
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign out_data = mem_data_r[rd_ptr_r];
   assign out_addr = mem_addr_r[rd_ptr_r];
   assign err_sel  = err_sel_r;
   assign count    = count_r;
   assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_writeback_select_pipe.sv
// Scoreboard bench for writeback_select_pipe with NUM_SRC=7, DEPTH=2.
module tb_writeback_select_pipe;

   localparam int DW = 32;
   localparam int NS = 7;
   localparam int DP = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NS*DW-1:0] src_data;
   logic [2:0]      src_sel = 3'd0;
   logic [4:0]      dst_addr = 5'd0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DW-1:0]   out_data;
   logic [4:0]      out_addr;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            flush = 1'b0;
   logic            err_clr = 1'b0;
   logic            err_sel;
   logic [1:0]      count;
   logic [7:0]      drop_cnt;

   logic [DW-1:0]   src_w [NS];
   logic [36:0]     sb [$];
   logic [36:0]     ent;
   logic [7:0]      drop_exp = 8'd0;
   int              n_vec = 0;
   int              n_bad = 0;
   logic            saw_valid;

   writeback_select_pipe #(.DATA_W(DW), .NUM_SRC(NS), .DEPTH(DP)) dut (
      .clk(clk), .reset(reset), .src_data(src_data), .src_sel(src_sel),
      .dst_addr(dst_addr), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
      .out_ready(out_ready), .flush(flush), .err_clr(err_clr),
      .err_sel(err_sel), .count(count), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NS; k++) src_data[k*DW +: DW] = src_w[k];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [2:0] s);
      if (s < 3'd7) return src_w[s];
      return 32'd0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] s, input logic [4:0] a);
      in_valid = v;
      src_sel  = s;
      dst_addr = a;
   endtask

   // Model of the queue and drop counter, sampled mid-cycle before the edge.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         drop_exp = 8'd0;
      end else if (flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_pop", 64'(out_valid), 64'd0);
            end else begin
               ent = sb.pop_front();
               chk("pop_addr", 64'(out_addr), 64'(ent[36:32]));
               chk("pop_data", 64'(out_data), 64'(ent[31:0]));
            end
         end
         if (in_valid && in_ready) begin
            if (dst_addr != 5'd0) sb.push_back({dst_addr, exp_word(src_sel)});
            else if (drop_exp != 8'hFF) drop_exp = drop_exp + 8'd1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < NS; k++) src_w[k] = 32'hA000_0000 + 32'(k) * 32'h0101_0011;
      src_w[6] = 32'h0000_00E3;
      step(); step();
      reset = 1'b0;
      step();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("rst_err_sel", 64'(err_sel), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

      // Single push with immediate drain
      out_ready = 1'b1;
      drive(1'b1, 3'd6, 5'd9);
      step();
      drive(1'b0, 3'd0, 5'd0);
      chk("lat1_valid", 64'(out_valid), 64'd1);
      chk("lat1_data", 64'(out_data), 64'h0000_00E3);
      chk("lat1_addr", 64'(out_addr), 64'd9);
      step();
      chk("lat1_count_after", 64'(count), 64'd0);

      // Fill, stall, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 5'd1); step();
      drive(1'b1, 3'd1, 5'd2); step();
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_count", 64'(count), 64'd2);
      drive(1'b1, 3'd2, 5'd3); step(); step();
      chk("stall_count", 64'(count), 64'd2);
      chk("stall_addr", 64'(out_addr), 64'd1);
      chk("stall_data", 64'(out_data), 64'(src_w[0]));
      out_ready = 1'b1;
      step();
      chk("drain1_count", 64'(count), 64'd1);
      step();
      chk("pushpop_count", 64'(count), 64'd1);
      drive(1'b0, 3'd0, 5'd0);
      step();
      chk("drain_count", 64'(count), 64'd0);
      chk("no_err_in_range", 64'(err_sel), 64'd0);

      // Out-of-range select and error clear priority
      out_ready = 1'b0;
      drive(1'b1, 3'd7, 5'd4); step();
      drive(1'b0, 3'd0, 5'd0);
      chk("bad_sel_err", 64'(err_sel), 64'd1);
      chk("bad_sel_data", 64'(out_data), 64'd0);
      chk("bad_sel_addr", 64'(out_addr), 64'd4);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("err_clr", 64'(err_sel), 64'd0);
      drive(1'b1, 3'd7, 5'd5); err_clr = 1'b1; step();
      drive(1'b0, 3'd0, 5'd0); err_clr = 1'b0;
      chk("err_set_wins", 64'(err_sel), 64'd1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("err_clr2", 64'(err_sel), 64'd0);
      out_ready = 1'b1;
      step(); step();
      chk("bad_drain_count", 64'(count), 64'd0);

      // Back-to-back push and pop keeps one entry in flight
      drive(1'b1, 3'd3, 5'd20); step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 3'(i % 7), 5'(21 + i));
         step();
         chk("stream_count", 64'(count), 64'd1);
      end
      drive(1'b0, 3'd0, 5'd0); step();
      chk("stream_drain", 64'(count), 64'd0);

      // Register-0 writes are dropped and counted with saturation
      saw_valid = 1'b0;
      drive(1'b1, 3'd1, 5'd0);
      for (int i = 0; i < 300; i++) begin
         step();
         if (out_valid) saw_valid = 1'b1;
         if (i == 9) chk("drop_cnt_10", 64'(drop_cnt), 64'd10);
      end
      drive(1'b0, 3'd0, 5'd0);
      chk("drop_no_valid", 64'(saw_valid), 64'd0);
      chk("drop_sat", 64'(drop_cnt), 64'd255);
      chk("drop_model", 64'(drop_cnt), 64'(drop_exp));

      // Flush on a full queue, and flush beating a same-cycle push
      out_ready = 1'b0;
      drive(1'b1, 3'd2, 5'd7); step();
      drive(1'b1, 3'd3, 5'd8); step();
      chk("pre_flush_count", 64'(count), 64'd2);
      flush = 1'b1; drive(1'b1, 3'd4, 5'd9); step();
      flush = 1'b0; drive(1'b0, 3'd0, 5'd0);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      drive(1'b1, 3'd5, 5'd10); step();
      flush = 1'b1; drive(1'b1, 3'd1, 5'd11); step();
      flush = 1'b0; drive(1'b0, 3'd0, 5'd0);
      chk("flush_push_count", 64'(count), 64'd0);
      step();
      chk("flush_push_lost", 64'(out_valid), 64'd0);
      chk("flush_keeps_drop", 64'(drop_cnt), 64'd255);

      // Mid-operation reset overrides everything
      drive(1'b1, 3'd7, 5'd11); step();
      drive(1'b1, 3'd3, 5'd12); step();
      drive(1'b0, 3'd0, 5'd0);
      chk("pre_rst_count", 64'(count), 64'd2);
      chk("pre_rst_err", 64'(err_sel), 64'd1);
      reset = 1'b1; flush = 1'b1; err_clr = 1'b1; out_ready = 1'b1;
      drive(1'b1, 3'd2, 5'd13);
      step();
      reset = 1'b0; flush = 1'b0; err_clr = 1'b0; out_ready = 1'b0;
      drive(1'b0, 3'd0, 5'd0);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_data", 64'(out_data), 64'd0);
      chk("mid_rst_addr", 64'(out_addr), 64'd0);
      chk("mid_rst_err", 64'(err_sel), 64'd0);
      chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      step();
      chk("mid_rst_push_lost", 64'(out_valid), 64'd0);
      chk("sb_left", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/writeback_select_pipe.md
WRITEBACK_SELECT_PIPE -- requirements
Module: writeback_select_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of each source word and of the output data.
REQ-002 Parameter NUM_SRC, default 8, number of write-back sources; legal range 2..16.
REQ-003 Parameter DEPTH, default 2, output queue entries; legal range 1..8.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 src_data  in  NUM_SRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W].
REQ-007 src_sel  in  SEL_W=$clog2(NUM_SRC)  encoded source select.
REQ-008 dst_addr  in  5  destination register number.
REQ-009 in_valid  in  1  write-back request present.
REQ-010 in_ready  out  1  queue can accept; equals (count < DEPTH); no combinational path from out_ready.
REQ-011 out_data  out  DATA_W  head-entry data to the register file.
REQ-012 out_addr  out  5  head-entry destination register.
REQ-013 out_valid  out  1  head entry present (count != 0).
REQ-014 out_ready  in  1  register file accepts head entry.
REQ-015 flush  in  1  discard all queued entries.
REQ-016 err_clr  in  1  clears err_sel.
REQ-017 err_sel  out  1  sticky: an out-of-range select was accepted.
REQ-018 count  out  $clog2(DEPTH+1)  queued entries.
REQ-019 drop_cnt  out  8  saturating count of accepted writes to register 0.

Function
REQ-020 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-021 On push with dst_addr != 0, the selected source word and dst_addr SHALL be written at the tail; the entry is visible at out_* the following cycle when the queue was empty (latency 1).
REQ-022 src_sel >= NUM_SRC on push SHALL enqueue data 0 and set err_sel the next cycle; no latch or hold of prior value.
REQ-023 Push with dst_addr == 0 SHALL be consumed without enqueue, count unchanged by it, drop_cnt incremented, saturating at 255.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; legal at count == DEPTH only for the pop side (in_ready low).
REQ-025 out_data/out_addr SHALL remain stable while out_valid && !out_ready.
REQ-026 Pointers SHALL wrap modulo DEPTH, including non-power-of-two DEPTH.
REQ-027 flush SHALL set count to 0 next cycle, overriding any same-cycle push or pop; a same-cycle push is lost and not counted in drop_cnt; err_sel and drop_cnt unaffected.
REQ-028 err_clr SHALL clear err_sel next cycle; a same-cycle error set wins over err_clr.
REQ-029 Queue state machine: EMPTY (count 0), PARTIAL, FULL (count DEPTH); transitions only via push/pop/flush per REQ-020..027; DEPTH 1 has no PARTIAL.

Reset
REQ-030 reset SHALL, on the clock edge, set count 0, pointers 0, out_valid 0, out_data 0, out_addr 0, err_sel 0, drop_cnt 0; in_ready reads 1 the cycle after.
REQ-031 reset asserted mid-operation SHALL discard all entries and override flush, push, pop and err_clr.

Structure
REQ-032 Shared package writeback_pkg SHALL hold REG_ADDR_W=5, DROP_CNT_W=8 and the source index constants (LS=0, HI=1, LO=2, SHIFT=3, CONST227=4, SE1_32=5, ALUOUT=6).
REQ-033 One sub-module, wb_src_mux (parametrised, combinational, full default), SHALL perform selection; queue logic lives in the top module.

Verification
REQ-034 Push sel=6, src6=0x0000_00E3, addr=9, out_ready=1 -> next cycle out_valid=1, out_data=0x0000_00E3, out_addr=9; count returns 0 after pop.
REQ-035 DEPTH=2, out_ready=0, push three (addr 1,2,3) -> in_ready=0 after second, third held; raise out_ready -> outputs addr 1,2,3 in order.
REQ-036 Push sel=7 (NUM_SRC=7), addr=4 -> entry data 0, err_sel=1; err_clr pulse -> err_sel=0.
REQ-037 Push 300 writes with addr=0 -> out_valid never 1, drop_cnt=255.
REQ-038 Queue full, flush with simultaneous push -> count=0, out_valid=0 next cycle, pushed entry absent.
REQ-039 Queue holding 2 entries, err_sel=1, assert reset one cycle -> all outputs zero, in_ready=1 the cycle after.
